// File: rtl/resp_capture_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : resp_capture_checker_if
// Brief    : Golden-load, pattern/response stream and result bundle for the
//            response capture checker.
// Revision : 1.0
// ============================================================================
interface resp_capture_checker_if #(
    parameter int NIN = 6
);
    logic           gold_we;
    logic [NIN-1:0] gold_addr;
    logic           gold_bit;
    logic           start;
    logic           pat_valid;
    logic [NIN-1:0] pat;
    logic           resp;
    logic           pat_ready;
    logic           busy;
    logic           done;
    logic [NIN:0]   mismatch_cnt;
    logic           first_fail_valid;
    logic [NIN-1:0] first_fail_pat;
    logic           order_err;
    logic [15:0]    signature;

    modport master (
        output gold_we, gold_addr, gold_bit, start, pat_valid, pat, resp,
        input  pat_ready, busy, done, mismatch_cnt, first_fail_valid,
               first_fail_pat, order_err, signature
    );

    modport slave (
        input  gold_we, gold_addr, gold_bit, start, pat_valid, pat, resp,
        output pat_ready, busy, done, mismatch_cnt, first_fail_valid,
               first_fail_pat, order_err, signature
    );
endinterface
`default_nettype wire

// File: rtl/resp_capture_checker.sv
`default_nettype none
// ============================================================================
// Module   : resp_capture_checker
// Brief    : Checks an exhaustive ascending pattern/response stream against a
//            golden bitmap; reports mismatches, first fail, order and MISR.
// Revision : 1.0
// ============================================================================
module resp_capture_checker #(
    parameter int NIN = 6
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    resp_capture_checker_if.slave bus
);
    localparam int unsigned  C_DEPTH    = 1 << NIN;
    localparam logic [NIN:0] C_LAST_IDX = (NIN+1)'(C_DEPTH - 1);
    localparam logic [NIN:0] C_CNT_MAX  = '1;
    localparam logic [15:0]  C_MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [C_DEPTH-1:0] r_gold;
    logic [NIN:0]     r_exp_idx;
    logic [NIN:0]     r_mismatch_cnt;
    logic             r_first_fail_valid;
    logic [NIN-1:0]   r_first_fail_pat;
    logic             r_order_err;
    logic             r_done;
    logic [15:0]      r_sig;

    logic             w_accept;
    logic             w_last;
    logic             w_mismatch;
    logic [15:0]      w_sig_nxt;

    // A start pulse in CAPTURE restarts the run, so the pair on that cycle is dropped.
    assign w_accept   = (r_state == S_CAPTURE) && bus.pat_valid && !bus.start;
    assign w_last     = w_accept && (r_exp_idx == C_LAST_IDX);
    assign w_mismatch = (bus.resp != r_gold[bus.pat]);
    assign w_sig_nxt  = {r_sig[14:0], 1'b0}
                      ^ (r_sig[15] ? C_MISR_POLY : 16'h0000)
                      ^ 16'({bus.pat, bus.resp});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (bus.start)   w_state_nxt = S_CAPTURE;
                else if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE:    if (bus.start) w_state_nxt = S_CAPTURE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Gold bitmap is writable only before the first run after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gold <= '0;
        end else if ((r_state == S_IDLE) && bus.gold_we) begin
            r_gold[bus.gold_addr] <= bus.gold_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_exp_idx          <= '0;
            r_mismatch_cnt     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_pat   <= '0;
            r_order_err        <= 1'b0;
            r_done             <= 1'b0;
            r_sig              <= 16'hFFFF;
        end else if (bus.start) begin
            r_exp_idx          <= '0;
            r_mismatch_cnt     <= '0;
            r_first_fail_valid <= 1'b0;
            r_first_fail_pat   <= '0;
            r_order_err        <= 1'b0;
            r_done             <= 1'b0;
            r_sig              <= 16'hFFFF;
        end else if (w_accept) begin
            if (w_mismatch) begin
                if (r_mismatch_cnt != C_CNT_MAX) begin
                    r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
                end
                if (!r_first_fail_valid) begin
                    r_first_fail_valid <= 1'b1;
                    r_first_fail_pat   <= bus.pat;
                end
            end
            if ({1'b0, bus.pat} != r_exp_idx) begin
                r_order_err <= 1'b1;
            end
            r_sig     <= w_sig_nxt;
            r_exp_idx <= r_exp_idx + 1'b1;
            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign bus.pat_ready        = (r_state == S_CAPTURE);
    assign bus.busy             = (r_state == S_CAPTURE);
    assign bus.done             = r_done;
    assign bus.mismatch_cnt     = r_mismatch_cnt;
    assign bus.first_fail_valid = r_first_fail_valid;
    assign bus.first_fail_pat   = r_first_fail_pat;
    assign bus.order_err        = r_order_err;
    assign bus.signature        = r_sig;
endmodule
`default_nettype wire

// File: tb/tb_resp_capture_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_resp_capture_checker
// Brief    : Scoreboard bench for resp_capture_checker (NIN = 6).
// Revision : 1.0
// ============================================================================
module tb_resp_capture_checker;
    localparam int NIN = 6;
    localparam int N   = 1 << NIN;

    typedef struct packed {
        logic [NIN:0]   cnt;
        logic           ffv;
        logic [NIN-1:0] ffp;
        logic           oerr;
        logic [15:0]    sig;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    resp_capture_checker_if #(.NIN(NIN)) bus();

    resp_capture_checker #(.NIN(NIN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t         exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [N-1:0] m_gold   = '0;
    res_t         m;
    int           m_idx;
    int           seq[N];
    logic         prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [NIN-1:0] p, input logic r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {{(15-NIN){1'b0}}, p, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.gold_we = 1'b0; bus.gold_addr = '0; bus.gold_bit = 1'b0;
        bus.start = 1'b0; bus.pat_valid = 1'b0; bus.pat = '0; bus.resp = 1'b0;
    endtask

    task automatic model_clear;
        m = '0;
        m.sig = 16'hFFFF;
        m_idx = 0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        idle_inputs();
        m_gold = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pat_ready"}, 32'(bus.pat_ready), 0);
        chk({tag, "_busy"},      32'(bus.busy), 0);
        chk({tag, "_done"},      32'(bus.done), 0);
        chk({tag, "_cnt"},       32'(bus.mismatch_cnt), 0);
        chk({tag, "_ffv"},       32'(bus.first_fail_valid), 0);
        chk({tag, "_ffp"},       32'(bus.first_fail_pat), 0);
        chk({tag, "_order"},     32'(bus.order_err), 0);
        chk({tag, "_sig"},       32'(bus.signature), 32'hFFFF);
    endtask

    task automatic load_gold(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            bus.gold_we = 1'b1; bus.gold_addr = NIN'(i); bus.gold_bit = g[i];
            tick();
        end
        bus.gold_we = 1'b0;
        m_gold = g;
    endtask

    task automatic start_run;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_clear();
    endtask

    // Drives one pair, updating the model as the DUT should on its accept edge.
    task automatic feed(input int p, input logic r, input int gap);
        repeat (gap) begin
            bus.pat_valid = 1'b0; bus.pat = NIN'($urandom); bus.resp = 1'($urandom);
            tick();
        end
        bus.pat_valid = 1'b1; bus.pat = NIN'(p); bus.resp = r;
        if (r != m_gold[p]) begin
            if (m.cnt != '1) m.cnt = m.cnt + 1'b1;
            if (!m.ffv) begin m.ffv = 1'b1; m.ffp = NIN'(p); end
        end
        if (p != m_idx) m.oerr = 1'b1;
        m.sig = misr_step(m.sig, NIN'(p), r);
        m_idx++;
        if (m_idx == N) exp_q.push_back(m);
        tick();
        bus.pat_valid = 1'b0;
    endtask

    task automatic run_all(input int gapmax, input logic r);
        for (int k = 0; k < N; k++) begin
            if (k == N-1) chk("done_early", 32'(bus.done), 0);
            feed(seq[k], r, (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
        end
        chk("done_rise", 32'(bus.done), 1);
        chk("ready_fall", 32'(bus.pat_ready), 0);
    endtask

    always @(negedge clk) begin
        if (bus.done && !prev_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_cnt",   32'(bus.mismatch_cnt),     32'(e.cnt));
                chk("sb_ffv",   32'(bus.first_fail_valid), 32'(e.ffv));
                chk("sb_ffp",   32'(bus.first_fail_pat),   32'(e.ffp));
                chk("sb_order", 32'(bus.order_err),        32'(e.oerr));
                chk("sb_sig",   32'(bus.signature),        32'(e.sig));
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        idle_inputs();
        model_clear();
        do_reset();
        chk_reset_vals("reset");

        bus.pat_valid = 1'b1; bus.pat = NIN'(7); bus.resp = 1'b1;
        repeat (3) tick();
        bus.pat_valid = 1'b0;
        chk("idle_sig", 32'(bus.signature), 32'hFFFF);
        chk("idle_cnt", 32'(bus.mismatch_cnt), 0);

        // Clean run: all-zero gold, all-zero responses, ascending order
        for (int i = 0; i < N; i++) seq[i] = i;
        load_gold('0);
        start_run();
        chk("ready_rise", 32'(bus.pat_ready), 1);
        chk("busy_rise",  32'(bus.busy), 1);
        run_all(0, 1'b0);
        tick();
        chk("clean_cnt",   32'(bus.mismatch_cnt), 0);
        chk("clean_order", 32'(bus.order_err), 0);

        // Two golden ones, random gaps
        do_reset();
        load_gold((64'd1 << 5) | (64'd1 << 40));
        start_run();
        run_all(3, 1'b0);
        tick();
        chk("mm_cnt", 32'(bus.mismatch_cnt), 2);
        chk("mm_ffp", 32'(bus.first_fail_pat), 5);
        chk("mm_ffv", 32'(bus.first_fail_valid), 1);

        bus.pat_valid = 1'b1; bus.pat = NIN'(9); bus.resp = 1'b1;
        repeat (4) tick();
        bus.pat_valid = 1'b0;
        chk("done_hold_sig", 32'(bus.signature), 32'(m.sig));
        chk("done_hold_cnt", 32'(bus.mismatch_cnt), 2);

        // Out-of-order stream 0,1,3,2,4..63, restarted from DONE
        seq[2] = 3; seq[3] = 2;
        start_run();
        run_all(0, 1'b0);
        tick();
        chk("ord_err", 32'(bus.order_err), 1);
        chk("ord_cnt", 32'(bus.mismatch_cnt), 2);

        // Mid-run restart with gold writes attempted during CAPTURE
        seq[2] = 2; seq[3] = 3;
        start_run();
        bus.gold_we = 1'b1; bus.gold_addr = NIN'(10); bus.gold_bit = 1'b1;
        for (int k = 0; k < 20; k++) feed(k, 1'b1, 0);
        bus.gold_we = 1'b0;
        bus.start = 1'b1; bus.pat_valid = 1'b1; bus.pat = NIN'(20); bus.resp = 1'b1;
        tick();
        bus.start = 1'b0; bus.pat_valid = 1'b0;
        model_clear();
        chk("rs_cnt",  32'(bus.mismatch_cnt), 0);
        chk("rs_sig",  32'(bus.signature), 32'hFFFF);
        chk("rs_ffv",  32'(bus.first_fail_valid), 0);
        chk("rs_done", 32'(bus.done), 0);
        chk("rs_busy", 32'(bus.busy), 1);
        run_all(1, 1'b0);
        tick();
        chk("rs_gold_cnt", 32'(bus.mismatch_cnt), 2);

        // Asynchronous reset mid-run
        start_run();
        for (int k = 0; k < 30; k++) feed(k, 1'b1, 0);
        chk("pre_rst_cnt", 32'(bus.mismatch_cnt), 29);
        bus.pat_valid = 1'b1; bus.pat = NIN'(30); bus.resp = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        bus.pat_valid = 1'b0;
        m_gold = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_in_rst", 32'(bus.busy), 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 0);
        start_run();
        run_all(0, 1'b0);
        tick();
        chk("gold_cleared_cnt", 32'(bus.mismatch_cnt), 0);

        tick(); tick();
        chk("sb_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/resp_capture_checker.md
# resp_capture_checker

Hardware reader for exhaustive-stimulus trojan-detection runs. It accepts one (pattern, response) pair per cycle from the pattern-driving side and checks the sequence is strictly ascending from 0 to 2^NIN-1. Each response is compared against a golden-response bitmap loaded beforehand. The block reports the mismatch count, the first failing pattern and a 16-bit MISR signature of the stream. It sits between the stimulus generator/DUT pair and the result-logging path.

## Interface
- NIN, 6, pattern width; the pattern space is 2^NIN entries (supported range 1..15)
- CK  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- gold_we  in  1  golden bitmap write strobe; honoured only in IDLE
- gold_addr  in  NIN  golden bitmap write index
- gold_bit  in  1  expected response for pattern gold_addr
- start  in  1  begin a capture run (single-cycle pulse)
- pat_valid  in  1  pattern/response pair is present
- pat  in  NIN  applied pattern
- resp  in  1  DUT response for pat
- pat_ready  out  1  high in CAPTURE; a pair is accepted when pat_valid && pat_ready
- busy  out  1  high in CAPTURE
- done  out  1  run completed; sticky until start or reset
- mismatch_cnt  out  NIN+1  count of accepted pairs with resp != gold[pat]
- first_fail_valid  out  1  at least one mismatch has been recorded
- first_fail_pat  out  NIN  pattern of the first mismatch
- order_err  out  1  sticky; an accepted pat differed from the expected index
- signature  out  16  MISR state

## Operation
- States: IDLE, CAPTURE, DONE. Reset enters IDLE.
- IDLE:
  - gold_we writes gold[gold_addr] <= gold_bit.
  - start moves to CAPTURE and, in the same edge, clears: exp_idx=0, mismatch_cnt=0, first_fail_valid=0, first_fail_pat=0, order_err=0, done=0, signature=16'hFFFF.
- CAPTURE, on each accepted pair:
  - Mismatch when resp != gold[pat]: mismatch_cnt increments, saturating at 2^(NIN+1)-1. If first_fail_valid=0, latch first_fail_pat=pat and set first_fail_valid.
  - Order check: if pat != exp_idx, set order_err. The comparison with gold still uses pat, not exp_idx.
  - MISR update: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ zero_extend({pat,resp}). The data word is NIN+1 bits, with resp as the LSB.
  - exp_idx increments (NIN+1 bits wide, no wrap).
  - If exp_idx == 2^NIN-1 before the increment, the accept is the last one: go to DONE and set done.
- gold_we is ignored outside IDLE.
- start while in CAPTURE restarts the run: same clears as above, stays in CAPTURE, and the pair on that cycle is not accepted.
- DONE: pat_ready=0. Outputs hold. start returns to CAPTURE with the clears. No path back to IDLE except reset, so the gold bitmap can only be reloaded after reset.
- pat_valid while not ready is dropped silently and sets no error.

## Timing
- Reset values: pat_ready=0, busy=0, done=0, mismatch_cnt=0, first_fail_valid=0, first_fail_pat=0, order_err=0, signature=16'hFFFF, all gold bits=0, state IDLE.
- Reset assertion is immediate and asynchronous, including mid-run. The partially captured run is discarded.
- pat_ready and busy are registered from state. They go high the cycle after the start edge.
- Every output reflects an accepted pair one cycle after the accepting edge (single-stage registered).
- done rises the cycle after the 2^NIN-th accept, and pat_ready falls in that same cycle.
- Throughput is one pair per cycle. A full run is 2^NIN accept cycles plus 1 cycle of start latency.
- Simultaneous gold_we and start in IDLE: the gold write completes, then the run starts.

## Test plan
- Reset and defaults: load gold all zero, start, feed pat 0..63 ascending with resp=0 -> mismatch_cnt=0, first_fail_valid=0, order_err=0, done=1 exactly one cycle after the 64th accept, signature matches the reference-model MISR value.
- Mismatch capture: gold[5]=1 and gold[40]=1, all resp=0 -> mismatch_cnt=2, first_fail_pat=5, first_fail_valid=1.
- Order error: feed 0,1,3,2,4..63 -> order_err=1, still done after 64 accepts, mismatches computed against the received pat.
- Backpressure and gaps: random pat_valid gaps -> identical results to the gapless run. pat_valid asserted in IDLE/DONE -> no counter or signature change.
- Restart: start pulse at pat 20 mid-run -> counters cleared, signature=16'hFFFF, the next accepted pat must be 0. Also gold_we during CAPTURE -> gold bitmap unchanged.
- Async reset: pull reset low mid-cycle at pat 30 -> all outputs at reset values immediately, gold bitmap cleared, start ignored until reset=1.
